svm_axil_regs: RTL and testbench
================================

// Module: svm_axil_regs
// PURPOSE
//  AXI4-Lite slave register file on the host side of the SVM classifier boundary.
//  Converts processor reads/writes into the start level toward the boundary register
//  stage, and exposes that stage's registered ready, classified-number and state
//  outputs as read-only registers.
//  Adds a sticky DONE flag plus interrupt so software need not poll ready.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  5   AXI byte-address width; decode uses addr[4:2]
// PORTS
//  clk            in   1   single clock, all logic rising-edge
//  reset          in   1   asynchronous, active-low reset
//  s_axi_awaddr   in   5   write address
//  s_axi_awvalid  in   1   write address valid
//  s_axi_awready  out  1   write address ready
//  s_axi_wdata    in   32  write data
//  s_axi_wstrb    in   4   write byte strobes; only bit0 used
//  s_axi_wvalid   in   1   write data valid
//  s_axi_wready   out  1   write data ready
//  s_axi_bresp    out  2   write response: 00 OKAY, 10 SLVERR
//  s_axi_bvalid   out  1   write response valid
//  s_axi_bready   in   1   write response ready
//  s_axi_araddr   in   5   read address
//  s_axi_arvalid  in   1   read address valid
//  s_axi_arready  out  1   read address ready
//  s_axi_rdata    out  32  read data
//  s_axi_rresp    out  2   read response: 00 OKAY, 10 SLVERR
//  s_axi_rvalid   out  1   read data valid
//  s_axi_rready   in   1   read data ready
//  start_axi_o    out  1   start level to boundary register stage
//  ready_axi_i    in   1   registered SVM ready
//  cl_num_axi_i   in   4   registered classified digit
//  state_axi_i    in   4   registered SVM state code
//  irq_o          out  1   level interrupt = DONE & IRQ_EN
// BEHAVIOUR
//  Register map (byte offset):
//   0x00 CTRL    [0] START (RW), [1] IRQ_EN (RW)
//   0x04 STATUS  [0] ready_axi_i (RO), [1] DONE (sticky, W1C)
//   0x08 CL_NUM  [3:0] cl_num_axi_i (RO)
//   0x0C STATE   [3:0] state_axi_i (RO)
//   0x10-0x1C    unmapped: reads return 0, writes ignored; both respond SLVERR
//  Unused bits read 0. Writes to RO fields are ignored with OKAY response.
//  Write FSM W_IDLE/W_RESP:
//   - In W_IDLE, waits for awvalid AND wvalid in the same cycle.
//   - On that cycle awready and wready pulse high together for exactly 1 cycle;
//     register update takes effect at the same edge. Next state is W_RESP.
//   - In W_RESP, bvalid is held high until bready, then returns to W_IDLE.
//   - A lone awvalid or lone wvalid is never accepted.
//  Read FSM R_IDLE/R_DATA:
//   - In R_IDLE, arvalid causes a 1-cycle arready pulse.
//   - rdata/rresp are registered at that edge; rvalid is high next cycle.
//   - rdata is held stable with rvalid until rready, then returns to R_IDLE.
//   - Read latency: 1 cycle after address handshake.
//  Read and write FSMs are independent and may complete in the same cycle.
//  wstrb[0]=0: write ignored, still OKAY (or SLVERR if unmapped).
//  DONE:
//   - Set on rising edge of ready_axi_i (registered previous value).
//   - Cleared by writing 1 to STATUS[1].
//   - Set and clear in the same cycle: set wins.
//  START is a software-held level, never auto-cleared.
//  Reset (async, any time, including mid-transaction): all ready/valid outputs 0,
//  bresp/rresp/rdata 0, START 0, IRQ_EN 0, DONE 0, ready-edge reg 0, irq_o 0,
//  both FSMs return to IDLE. In-flight transactions are dropped.
// TESTING
//  - Reset release: every output 0; read 0x00 returns 0 with rresp 00.
//  - Write 0x00 = 0x3: awready/wready pulse in the same cycle, bvalid next cycle;
//    start_axi_o=1; readback 0x3.
//  - ready_axi_i 0->1 with cl_num_axi_i=7, IRQ_EN=1: DONE=1, irq_o=1;
//    read 0x08 = 0x7; write 0x04 = 0x2 clears DONE and irq_o.
//  - W1C write to DONE in the same cycle as a new ready rising edge: DONE stays 1.
//  - Stalls: bready held low 5 cycles keeps bvalid=1 and blocks the next write;
//    rready held low keeps rdata stable.
//  - Reads/writes to 0x14 return SLVERR; async reset asserted during W_RESP
//    drops bvalid immediately.

Source files
------------

// File: rtl/svm_axil_regs.sv
// rtl/svm_axil_regs.sv - AXI4-Lite register file for the SVM classifier host boundary
// Drives START/IRQ_EN, mirrors ready/cl_num/state and keeps a sticky DONE with a level interrupt.
module svm_axil_regs #(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 5
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic                            start_axi_o,
   input  logic                            ready_axi_i,
   input  logic [3:0]                      cl_num_axi_i,
   input  logic [3:0]                      state_axi_i,
   output logic                            irq_o
);

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t r_wstate, w_wstate_nxt;
   rstate_t r_rstate, w_rstate_nxt;

   logic                          r_start;
   logic                          r_irq_en;
   logic                          r_done;
   logic                          r_ready_d;
   logic [1:0]                    r_bresp;
   logic [1:0]                    r_rresp;
   logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;

   logic                          w_wr_fire;
   logic                          w_rd_fire;
   logic [2:0]                    w_wr_idx;
   logic [2:0]                    w_rd_idx;
   logic                          w_ready_rise;
   logic                          w_done_clr;
   logic [C_S_AXI_DATA_WIDTH-1:0] w_rdata;
   logic                          w_unused;

   assign w_wr_idx     = s_axi_awaddr[4:2];
   assign w_rd_idx     = s_axi_araddr[4:2];
   assign w_ready_rise = ready_axi_i & ~r_ready_d;
   assign w_done_clr   = w_wr_fire & s_axi_wstrb[0] & (w_wr_idx == 3'd1) & s_axi_wdata[1];
   assign w_unused     = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                           s_axi_wdata[C_S_AXI_DATA_WIDTH-1:2],
                           s_axi_wstrb[C_S_AXI_DATA_WIDTH/8-1:1]};

   // Write channel: address and data must arrive together before either is accepted.
   always_comb begin
      w_wstate_nxt  = r_wstate;
      s_axi_awready = 1'b0;
      s_axi_wready  = 1'b0;
      s_axi_bvalid  = 1'b0;
      w_wr_fire     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (s_axi_awvalid && s_axi_wvalid) begin
               s_axi_awready = 1'b1;
               s_axi_wready  = 1'b1;
               w_wr_fire     = 1'b1;
               w_wstate_nxt  = W_RESP;
            end
         end
         W_RESP: begin
            s_axi_bvalid = 1'b1;
            if (s_axi_bready) w_wstate_nxt = W_IDLE;
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      w_rstate_nxt  = r_rstate;
      s_axi_arready = 1'b0;
      s_axi_rvalid  = 1'b0;
      w_rd_fire     = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (s_axi_arvalid) begin
               s_axi_arready = 1'b1;
               w_rd_fire     = 1'b1;
               w_rstate_nxt  = R_DATA;
            end
         end
         R_DATA: begin
            s_axi_rvalid = 1'b1;
            if (s_axi_rready) w_rstate_nxt = R_IDLE;
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      w_rdata = '0;
      case (w_rd_idx)
         3'd0:    w_rdata[1:0] = {r_irq_en, r_start};
         3'd1:    w_rdata[1:0] = {r_done, ready_axi_i};
         3'd2:    w_rdata[3:0] = cl_num_axi_i;
         3'd3:    w_rdata[3:0] = state_axi_i;
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wstate  <= W_IDLE;
         r_rstate  <= R_IDLE;
         r_start   <= 1'b0;
         r_irq_en  <= 1'b0;
         r_done    <= 1'b0;
         r_ready_d <= 1'b0;
         r_bresp   <= RESP_OKAY;
         r_rresp   <= RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         r_wstate  <= w_wstate_nxt;
         r_rstate  <= w_rstate_nxt;
         r_ready_d <= ready_axi_i;
         if (w_wr_fire) begin
            r_bresp <= w_wr_idx[2] ? RESP_SLVERR : RESP_OKAY;
            if (s_axi_wstrb[0] && (w_wr_idx == 3'd0)) begin
               r_start  <= s_axi_wdata[0];
               r_irq_en <= s_axi_wdata[1];
            end
         end
         // A fresh completion must never be lost to a concurrent acknowledge.
         if (w_ready_rise)    r_done <= 1'b1;
         else if (w_done_clr) r_done <= 1'b0;
         if (w_rd_fire) begin
            r_rdata <= w_rdata;
            r_rresp <= w_rd_idx[2] ? RESP_SLVERR : RESP_OKAY;
         end
      end
   end

   assign s_axi_bresp = r_bresp;
   assign s_axi_rresp = r_rresp;
   assign s_axi_rdata = r_rdata;
   assign start_axi_o = r_start;
   assign irq_o       = r_done & r_irq_en;

endmodule

// File: tb/tb_svm_axil_regs.sv
// tb/tb_svm_axil_regs.sv - self-checking bench for svm_axil_regs
// Table vectors, hand-written corner sequences and a randomized run against a register-map model.
module tb_svm_axil_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  s_axi_awaddr;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [4:0]  s_axi_araddr;
   logic        s_axi_arvalid;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready;
   logic        start_axi_o;
   logic        ready_axi_i;
   logic [3:0]  cl_num_axi_i;
   logic [3:0]  state_axi_i;
   logic        irq_o;

   int n_checks = 0;
   int n_errors = 0;

   // Register-map model
   logic       m_start, m_irq_en, m_done, m_ready;

   always #5 clk = ~clk;

   svm_axil_regs dut (
      .clk(clk), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
      .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
      .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
      .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .start_axi_o(start_axi_o),
      .ready_axi_i(ready_axi_i), .cl_num_axi_i(cl_num_axi_i), .state_axi_i(state_axi_i),
      .irq_o(irq_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents address+data together; returns once accepted (awready and wready seen together).
   task automatic wr_addr_data(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      bit done = 0;
      s_axi_awaddr  = a;
      s_axi_wdata   = d;
      s_axi_wstrb   = s;
      s_axi_awvalid = 1'b1;
      s_axi_wvalid  = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (s_axi_awready || s_axi_wready) begin
            chk("aw_w_ready_together", {31'd0, s_axi_wready}, {31'd0, s_axi_awready});
            done = 1;
         end
         step();
      end
      if (!done) chk("write_accept_timeout", 32'd0, 32'd1);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b0;
   endtask

   task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      wr_addr_data(a, d, s);
      s_axi_bready = 1'b1;
      @(negedge clk);
      chk("bvalid_next_cycle", {31'd0, s_axi_bvalid}, 32'd1);
      resp = s_axi_bresp;
      step();
      s_axi_bready = 1'b0;
      @(negedge clk);
      chk("bvalid_drops", {31'd0, s_axi_bvalid}, 32'd0);
      step();
   endtask

   task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output logic [1:0] resp);
      bit done = 0;
      s_axi_araddr  = a;
      s_axi_arvalid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (s_axi_arready) done = 1;
         step();
      end
      if (!done) chk("read_accept_timeout", 32'd0, 32'd1);
      s_axi_arvalid = 1'b0;
      s_axi_rready  = 1'b1;
      @(negedge clk);
      chk("rvalid_latency1", {31'd0, s_axi_rvalid}, 32'd1);
      d    = s_axi_rdata;
      resp = s_axi_rresp;
      step();
      s_axi_rready = 1'b0;
   endtask

   function automatic logic [1:0] model_wresp(input logic [4:0] a);
      return (a >= 5'h10) ? 2'b10 : 2'b00;
   endfunction

   function automatic logic [31:0] model_rdata(input logic [4:0] a);
      case (a >> 2)
         0: return 32'(m_start) | (32'(m_irq_en) << 1);
         1: return 32'(m_ready) | (32'(m_done) << 1);
         2: return 32'(cl_num_axi_i);
         3: return 32'(state_axi_i);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
      if (s[0]) begin
         if (a == 5'h00) begin
            m_start  = d[0];
            m_irq_en = d[1];
         end else if (a == 5'h04 && d[1]) begin
            m_done = 1'b0;
         end
      end
   endtask

   task automatic set_ready(input logic v);
      ready_axi_i = v;
      step();
      if (v && !m_ready) m_done = 1'b1;
      m_ready = v;
   endtask

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      logic [31:0] held;

      reset = 1'b0;
      s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
      s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
      s_axi_rready = 0; ready_axi_i = 0; cl_num_axi_i = 4'd5; state_axi_i = 4'd9;
      m_start = 0; m_irq_en = 0; m_done = 0; m_ready = 0;

      // vectors assume cl_num=5, state=9, ready=0
      vecs[0] = '{5'h00, 32'h3,        4'h1, 2'b00, 32'h3, 2'b00};
      vecs[1] = '{5'h00, 32'h1,        4'h0, 2'b00, 32'h3, 2'b00};
      vecs[2] = '{5'h00, 32'hFFFFFFFE, 4'h1, 2'b00, 32'h2, 2'b00};
      vecs[3] = '{5'h08, 32'hF,        4'h1, 2'b00, 32'h5, 2'b00};
      vecs[4] = '{5'h0C, 32'h0,        4'h1, 2'b00, 32'h9, 2'b00};
      vecs[5] = '{5'h14, 32'hFF,       4'h1, 2'b10, 32'h0, 2'b10};
      vecs[6] = '{5'h1C, 32'h1,        4'h1, 2'b10, 32'h0, 2'b10};
      vecs[7] = '{5'h04, 32'h3,        4'h1, 2'b00, 32'h0, 2'b00};
      vecs[8] = '{5'h00, 32'h0,        4'hF, 2'b00, 32'h0, 2'b00};

      repeat (3) step();
      reset = 1'b1;
      step();

      // reset state
      chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
      chk("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
      chk("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
      chk("rst_rdata",   s_axi_rdata,            32'd0);
      chk("rst_start",   {31'd0, start_axi_o},   32'd0);
      chk("rst_irq",     {31'd0, irq_o},         32'd0);
      axi_read(5'h00, rd, resp);
      chk("rst_read_ctrl", rd, 32'd0);
      chk("rst_read_resp", {30'd0, resp}, 32'd0);

      foreach (vecs[i]) begin
         axi_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb, resp);
         chk($sformatf("vec%0d_bresp", i), {30'd0, resp}, {30'd0, vecs[i].bresp});
         axi_read(vecs[i].addr, rd, resp);
         chk($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         chk($sformatf("vec%0d_rresp", i), {30'd0, resp}, {30'd0, vecs[i].rresp});
      end

      // lone awvalid / lone wvalid never accepted
      s_axi_awvalid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("lone_aw_awready", {31'd0, s_axi_awready}, 32'd0);
         step();
      end
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b1;
      @(negedge clk);
      chk("lone_w_wready", {31'd0, s_axi_wready}, 32'd0);
      step();
      s_axi_wvalid = 1'b0;

      // START level and DONE/irq flow
      axi_write(5'h00, 32'h3, 4'h1, resp);
      chk("start_level", {31'd0, start_axi_o}, 32'd1);
      cl_num_axi_i = 4'd7;
      step();
      ready_axi_i = 1'b1;
      step();
      @(negedge clk);
      chk("done_irq", {31'd0, irq_o}, 32'd1);
      step();
      axi_read(5'h04, rd, resp);
      chk("status_done", rd, 32'h3);
      axi_read(5'h08, rd, resp);
      chk("cl_num_7", rd, 32'h7);
      axi_write(5'h04, 32'h2, 4'h1, resp);
      chk("w1c_irq", {31'd0, irq_o}, 32'd0);
      axi_read(5'h04, rd, resp);
      chk("status_cleared", rd, 32'h1);

      // W1C coinciding with a new rising edge: set wins
      ready_axi_i = 1'b0;
      step();
      step();
      ready_axi_i = 1'b1;
      wr_addr_data(5'h04, 32'h2, 4'h1);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;
      step();
      axi_read(5'h04, rd, resp);
      chk("set_wins_status", rd, 32'h3);
      chk("set_wins_irq", {31'd0, irq_o}, 32'd1);

      // bready stall blocks the next write
      wr_addr_data(5'h00, 32'h1, 4'h1);
      s_axi_awaddr = 5'h00; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h1;
      s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bstall_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
         chk("bstall_awready", {31'd0, s_axi_awready}, 32'd0);
         step();
      end
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      chk("bstall_start_kept", {31'd0, start_axi_o}, 32'd1);
      s_axi_bready = 1'b1;
      step();
      s_axi_bready = 1'b0;

      // rready stall keeps rdata stable
      s_axi_araddr = 5'h00; s_axi_arvalid = 1'b1;
      step();
      s_axi_arvalid = 1'b0;
      cl_num_axi_i = 4'd2;
      @(negedge clk);
      held = s_axi_rdata;
      chk("rstall_first", held, 32'h1);
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         chk("rstall_rvalid", {31'd0, s_axi_rvalid}, 32'd1);
         chk("rstall_rdata", s_axi_rdata, held);
      end
      step();
      s_axi_rready = 1'b1;
      step();
      s_axi_rready = 1'b0;

      // async reset during W_RESP
      wr_addr_data(5'h00, 32'h3, 4'h1);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_mid_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      chk("rst_mid_start",  {31'd0, start_axi_o},  32'd0);
      chk("rst_mid_irq",    {31'd0, irq_o},        32'd0);
      step();
      ready_axi_i = 1'b0;
      step();
      reset = 1'b1;
      step();
      @(negedge clk);
      chk("post_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
      step();

      // randomized traffic against the model
      m_start = 0; m_irq_en = 0; m_done = 0; m_ready = 0;
      for (int it = 0; it < 60; it++) begin
         int op;
         logic [4:0]  a;
         logic [31:0] d;
         logic [3:0]  s;
         op = $urandom_range(0, 3);
         a  = 5'($urandom_range(0, 7) << 2);
         d  = $urandom;
         s  = 4'($urandom);
         case (op)
            0: begin
               axi_write(a, d, s, resp);
               model_write(a, d, s);
               chk("rnd_bresp", {30'd0, resp}, {30'd0, model_wresp(a)});
            end
            1: begin
               axi_read(a, rd, resp);
               chk("rnd_rdata", rd, model_rdata(a));
               chk("rnd_rresp", {30'd0, resp}, {30'd0, model_wresp(a)});
            end
            2: set_ready(1'($urandom));
            default: begin
               cl_num_axi_i = 4'($urandom);
               state_axi_i  = 4'($urandom);
               step();
            end
         endcase
         chk("rnd_start", {31'd0, start_axi_o}, {31'd0, m_start});
         chk("rnd_irq",   {31'd0, irq_o},       {31'd0, m_done & m_irq_en});
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
